// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity encodings and default frame geometry.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int UART_PRESCALE   = 8;
   localparam int UART_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchronizer, per-bit edge counter and 3-sample majority vote.
module uart_rx_sampler #(
   parameter int PRESCALE = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_rx,
   input  logic                        i_cnt_en,
   output logic                        o_rx_s,
   output logic [$clog2(PRESCALE)-1:0] o_edge_cnt,
   output logic                        o_sampled_bit,
   output logic                        o_bit_done
);

   localparam int EW = $clog2(PRESCALE);
   localparam logic [EW-1:0] E_ONE  = EW'(1);
   localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
   localparam logic [EW-1:0] S0     = EW'(PRESCALE / 2 - 1);
   localparam logic [EW-1:0] S1     = EW'(PRESCALE / 2);
   localparam logic [EW-1:0] S2     = EW'(PRESCALE / 2 + 1);

   logic [1:0]    r_sync;
   logic [EW-1:0] r_edge_cnt;
   logic [2:0]    r_samp;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync     <= 2'b11;
         r_edge_cnt <= '0;
         r_samp     <= 3'b111;
      end else begin
         r_sync <= {r_sync[0], i_rx};
         // counter parks at 0 while idle so a detected start cycle is sample 0
         if (!i_cnt_en)
            r_edge_cnt <= '0;
         else if (r_edge_cnt == E_LAST)
            r_edge_cnt <= '0;
         else
            r_edge_cnt <= r_edge_cnt + E_ONE;
         if (r_edge_cnt == S0 || r_edge_cnt == S1 || r_edge_cnt == S2)
            r_samp <= {r_samp[1:0], r_sync[1]};
      end
   end

   assign o_rx_s        = r_sync[1];
   assign o_edge_cnt    = r_edge_cnt;
   assign o_sampled_bit = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
   assign o_bit_done    = (r_edge_cnt == E_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop FSM over the voted bit stream, reporting
// good bytes or frame errors as single-cycle pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int PRESCALE   = UART_PRESCALE,
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic                  par_en,
   input  logic                  par_type,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int EW = $clog2(PRESCALE);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [EW-1:0] VOTE_AT  = EW'(PRESCALE / 2 + 2);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   logic                  w_rx_s;
   logic [EW-1:0]         w_edge_cnt;
   logic                  w_bit;
   logic                  w_bit_done;
   logic                  w_cnt_en;
   logic                  w_par_mis;
   uart_state_e           r_state, w_next;
   logic [BW-1:0]         r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par_en, r_par_type, r_perr;
   logic [DATA_WIDTH-1:0] r_p_data;
   logic                  r_data_valid, r_par_err, r_stp_err;

   uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_rx          (rx_in),
      .i_cnt_en      (w_cnt_en),
      .o_rx_s        (w_rx_s),
      .o_edge_cnt    (w_edge_cnt),
      .o_sampled_bit (w_bit),
      .o_bit_done    (w_bit_done)
   );

   assign w_cnt_en  = (w_next != IDLE);
   assign w_par_mis = ((^r_shift) ^ r_par_type) != w_bit;

   // every decision except false-start rejection is taken on the last cycle of
   // the bit, where the vote is already settled for any legal PRESCALE
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (!w_rx_s) w_next = START;
         START: begin
            if (w_edge_cnt == VOTE_AT && w_bit) w_next = IDLE;
            else if (w_bit_done)                w_next = DATA;
         end
         DATA:    if (w_bit_done && r_bit_cnt == LAST_BIT) w_next = r_par_en ? PARITY : STOP;
         PARITY:  if (w_bit_done) w_next = STOP;
         STOP:    if (w_bit_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_par_en     <= 1'b0;
         r_par_type   <= 1'b0;
         r_perr       <= 1'b0;
         r_p_data     <= '0;
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_data_valid <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
         case (r_state)
            IDLE: if (!w_rx_s) begin
               r_par_en   <= par_en;
               r_par_type <= par_type;
               r_perr     <= 1'b0;
               r_bit_cnt  <= '0;
            end
            DATA: if (w_bit_done) begin
               r_shift[r_bit_cnt] <= w_bit;
               r_bit_cnt          <= r_bit_cnt + BIT_ONE;
            end
            PARITY: if (w_bit_done && w_par_mis) r_perr <= 1'b1;
            STOP: if (w_bit_done) begin
               if (!r_perr && w_bit) begin
                  r_p_data     <= r_shift;
                  r_data_valid <= 1'b1;
               end else begin
                  r_par_err <= r_perr;
                  r_stp_err <= !w_bit;
               end
            end
            default: ;
         endcase
      end
   end

   assign p_data     = r_p_data;
   assign data_valid = r_data_valid;
   assign par_err    = r_par_err;
   assign stp_err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level model of expected pulses, data and timing.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int P  = UART_PRESCALE;
   localparam int DW = UART_DATA_WIDTH;

   typedef struct packed {
      logic [31:0]   cyc;
      logic          dv;
      logic          pe;
      logic          se;
      logic [DW-1:0] d;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst, rx_in, par_en, par_type;
   logic [DW-1:0] p_data;
   logic          data_valid, par_err, stp_err;

   int            cyc = 0;
   int            n_pass = 0, n_total = 0;
   ev_t           obs_q[$];
   logic [DW-1:0] exp_pdata;

   uart_rx #(.PRESCALE(P), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .par_type(par_type),
      .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      ev_t e;
      if (data_valid || par_err || stp_err) begin
         e.cyc = cyc; e.dv = data_valid; e.pe = par_err; e.se = stp_err; e.d = p_data;
         obs_q.push_back(e);
      end
   end

   function automatic string ev_str(input ev_t e);
      return $sformatf("cyc=%0d dv=%0b pe=%0b se=%0b d=%02h", e.cyc, e.dv, e.pe, e.se, e.d);
   endfunction

   // Frame-level model: start + data + optional parity + stop bits of P cycles,
   // first line-low edge plus two synchronizer/register cycles to the pulse.
   function automatic ev_t model_frame(input logic [DW-1:0] d, input logic pe, input logic flip,
                                       input logic stopv, input int sc, input logic [DW-1:0] prev);
      ev_t e;
      logic perr, serr;
      perr  = pe && flip;
      serr  = !stopv;
      e.cyc = sc + (2 + DW + (pe ? 1 : 0)) * P + 2;
      e.dv  = !perr && !serr;
      e.pe  = perr;
      e.se  = serr;
      e.d   = e.dv ? d : prev;
      return e;
   endfunction

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                             input logic flip, input logic stopv, input bit scramble,
                             output int sc);
      par_en = pe; par_type = pt;
      sc = cyc;
      rx_in = 1'b0;
      repeat (P) @(negedge clk);
      if (scramble) begin
         par_en = 1'($urandom); par_type = 1'($urandom);
      end
      for (int i = 0; i < DW; i++) begin
         rx_in = d[i];
         repeat (P) @(negedge clk);
      end
      if (pe) begin
         rx_in = (^d) ^ pt ^ flip;
         repeat (P) @(negedge clk);
      end
      rx_in = stopv;
      repeat (P) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; par_type = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({p_data, data_valid, par_err, stp_err} !== '0)
         $display("FAIL reset_outputs: got p_data=%02h dv=%0b pe=%0b se=%0b, want all 0",
                  p_data, data_valid, par_err, stp_err);
      else n_pass++;
      n_total++;
      if (dut.r_state !== IDLE || dut.u_sampler.r_edge_cnt !== '0)
         $display("FAIL reset_state: got state=%0d edge_cnt=%0d, want IDLE/0",
                  dut.r_state, dut.u_sampler.r_edge_cnt);
      else n_pass++;
      rst = 1'b0;
      exp_pdata = '0;
      idle(10);
   endtask

   task automatic test_single;
      int sc; ev_t e;
      obs_q.delete();
      send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b0, sc);
      idle(20);
      e = model_frame(8'hA5, 1'b1, 1'b0, 1'b1, sc, exp_pdata);
      exp_pdata = e.d;
      n_total++;
      if (obs_q.size() !== 1) $display("FAIL single_count: got %0d pulses, want 1", obs_q.size());
      else begin
         n_pass++;
         n_total++;
         if (obs_q[0] !== e) $display("FAIL single_frame: got %s, want %s", ev_str(obs_q[0]), ev_str(e));
         else n_pass++;
      end
   endtask

   task automatic test_parity_err;
      int sc; ev_t e;
      obs_q.delete();
      send_frame(8'h3C, 1'b1, PAR_ODD, 1'b1, 1'b1, 1'b0, sc);
      idle(20);
      e = model_frame(8'h3C, 1'b1, 1'b1, 1'b1, sc, exp_pdata);
      exp_pdata = e.d;
      n_total++;
      if (obs_q.size() !== 1) $display("FAIL parity_count: got %0d pulses, want 1", obs_q.size());
      else begin
         n_pass++;
         n_total++;
         if (obs_q[0] !== e) $display("FAIL parity_err: got %s, want %s", ev_str(obs_q[0]), ev_str(e));
         else n_pass++;
      end
   endtask

   task automatic test_stop_err;
      int sc; ev_t e;
      obs_q.delete();
      send_frame(8'h81, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0, sc);
      idle(20);
      e = model_frame(8'h81, 1'b0, 1'b0, 1'b0, sc, exp_pdata);
      exp_pdata = e.d;
      n_total++;
      if (obs_q.size() !== 1) $display("FAIL stop_count: got %0d pulses, want 1", obs_q.size());
      else begin
         n_pass++;
         n_total++;
         if (obs_q[0] !== e) $display("FAIL stop_err: got %s, want %s", ev_str(obs_q[0]), ev_str(e));
         else n_pass++;
      end
      n_total++;
      if (dut.r_state !== IDLE) $display("FAIL stop_idle: got state=%0d, want IDLE", dut.r_state);
      else n_pass++;
   endtask

   task automatic test_false_start;
      int sc; ev_t e;
      obs_q.delete();
      rx_in = 1'b0;
      repeat (2) @(negedge clk);
      idle(20);
      n_total++;
      if (obs_q.size() !== 0 || dut.r_state !== IDLE)
         $display("FAIL false_start: got %0d pulses state=%0d, want 0 pulses IDLE", obs_q.size(), dut.r_state);
      else n_pass++;
      send_frame(8'h5A, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0, sc);
      idle(20);
      e = model_frame(8'h5A, 1'b0, 1'b0, 1'b1, sc, exp_pdata);
      exp_pdata = e.d;
      n_total++;
      if (obs_q.size() !== 1 || obs_q[0] !== e)
         $display("FAIL after_false_start: got %0d pulses first=%s, want %s",
                  obs_q.size(), (obs_q.size() > 0) ? ev_str(obs_q[0]) : "none", ev_str(e));
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      int sc0, sc1; ev_t e0, e1;
      obs_q.delete();
      send_frame(8'h00, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0, sc0);
      send_frame(8'hFF, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0, sc1);
      idle(20);
      e0 = model_frame(8'h00, 1'b0, 1'b0, 1'b1, sc0, exp_pdata);
      e1 = model_frame(8'hFF, 1'b0, 1'b0, 1'b1, sc1, e0.d);
      exp_pdata = e1.d;
      n_total++;
      if (obs_q.size() !== 2) $display("FAIL b2b_count: got %0d pulses, want 2", obs_q.size());
      else begin
         n_pass++;
         n_total++;
         if (obs_q[0] !== e0) $display("FAIL b2b_first: got %s, want %s", ev_str(obs_q[0]), ev_str(e0));
         else n_pass++;
         n_total++;
         if (obs_q[1] !== e1) $display("FAIL b2b_second: got %s, want %s", ev_str(obs_q[1]), ev_str(e1));
         else n_pass++;
         n_total++;
         if (obs_q[1].cyc - obs_q[0].cyc !== 80)
            $display("FAIL b2b_spacing: got %0d cycles, want 80", obs_q[1].cyc - obs_q[0].cyc);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame;
      int sc; ev_t e;
      logic [DW-1:0] d;
      obs_q.delete();
      d = 8'hC3;
      par_en = 1'b0;
      rx_in = 1'b0;
      repeat (P) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx_in = d[i];
         repeat (P) @(negedge clk);
      end
      rx_in = d[3];
      repeat (P / 2) @(negedge clk);
      rst = 1'b1; rx_in = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_pdata = '0;
      n_total++;
      if ({p_data, data_valid, par_err, stp_err} !== '0 || dut.r_state !== IDLE)
         $display("FAIL midreset_outputs: got p_data=%02h dv=%0b pe=%0b se=%0b state=%0d, want 0 IDLE",
                  p_data, data_valid, par_err, stp_err, dut.r_state);
      else n_pass++;
      idle(100);
      n_total++;
      if (obs_q.size() !== 0) $display("FAIL midreset_pulses: got %0d pulses, want 0", obs_q.size());
      else n_pass++;
      send_frame(8'h12, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b0, sc);
      idle(20);
      e = model_frame(8'h12, 1'b0, 1'b0, 1'b1, sc, exp_pdata);
      exp_pdata = e.d;
      n_total++;
      if (obs_q.size() !== 1 || obs_q[0] !== e)
         $display("FAIL midreset_next: got %0d pulses first=%s, want %s",
                  obs_q.size(), (obs_q.size() > 0) ? ev_str(obs_q[0]) : "none", ev_str(e));
      else n_pass++;
   endtask

   task automatic test_break;
      int sc; ev_t e0, e1;
      obs_q.delete();
      par_en = 1'b0;
      sc = cyc;
      rx_in = 1'b0;
      repeat (2 * (DW + 2) * P) @(negedge clk);
      idle(30);
      e0 = model_frame('0, 1'b0, 1'b0, 1'b0, sc, exp_pdata);
      e1 = model_frame('0, 1'b0, 1'b0, 1'b0, sc + (DW + 2) * P, exp_pdata);
      n_total++;
      if (obs_q.size() !== 2) $display("FAIL break_count: got %0d pulses, want 2", obs_q.size());
      else begin
         n_pass++;
         n_total++;
         if (obs_q[0] !== e0 || obs_q[1] !== e1)
            $display("FAIL break_frames: got %s / %s, want %s / %s",
                     ev_str(obs_q[0]), ev_str(obs_q[1]), ev_str(e0), ev_str(e1));
         else n_pass++;
      end
      n_total++;
      if (dut.r_state !== IDLE) $display("FAIL break_idle: got state=%0d, want IDLE", dut.r_state);
      else n_pass++;
   endtask

   task automatic test_random;
      ev_t exp_q[$];
      ev_t e;
      int sc;
      logic [DW-1:0] d;
      logic pe, pt, flip, stopv;
      obs_q.delete();
      for (int n = 0; n < 24; n++) begin
         d     = DW'($urandom);
         pe    = 1'($urandom);
         pt    = 1'($urandom);
         flip  = ($urandom_range(0, 3) == 0);
         stopv = ($urandom_range(0, 3) != 0);
         send_frame(d, pe, pt, flip, stopv, ($urandom_range(0, 1) == 1), sc);
         e = model_frame(d, pe, flip, stopv, sc, exp_pdata);
         exp_pdata = e.d;
         exp_q.push_back(e);
         idle($urandom_range(0, 12));
      end
      idle(30);
      n_total++;
      if (obs_q.size() !== exp_q.size())
         $display("FAIL random_count: got %0d pulses, want %0d", obs_q.size(), exp_q.size());
      else begin
         n_pass++;
         foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_q[i])
               $display("FAIL random_frame%0d: got %s, want %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            else n_pass++;
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_parity_err();
      test_stop_err();
      test_false_start();
      test_back_to_back();
      test_reset_mid_frame();
      test_break();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
